fpu_req_arbiter: RTL and testbench

Round-robin arbiter that shares one fixed-latency FPU datapath among NUM_REQ requesters. It accepts at most one operation per cycle through a valid/ready handshake and drives the FPU issue interface from registers. A tag pipeline tracks each in-flight operation so that every result and exception is returned to the requester that issued it. The block sits between the requester ports and the FPU. Its idle output feeds the power-management logic.

---
 rtl/fpu_req_arbiter.sv | 122 ++++++++++++
 tb/tb_fpu_req_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: round-robin sharing of one fixed-latency FPU among NUM_REQ requesters,
// with a tag pipeline that routes each result back to the requester that issued it.
module fpu_req_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int FPU_LATENCY = 2,
   parameter int TAG_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk_gated,
   input  logic                          rst_n,
   input  logic                          arb_en,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [3*NUM_REQ-1:0]          req_op,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
   output logic                          fpu_valid_in,
   output logic [2:0]                    fpu_operation,
   output logic [DATA_WIDTH-1:0]         fpu_operand_a,
   output logic [DATA_WIDTH-1:0]         fpu_operand_b,
   input  logic                          fpu_valid_out,
   input  logic [DATA_WIDTH-1:0]         fpu_result,
   input  logic                          fpu_exception,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_result,
   output logic                          rsp_exception,
   output logic                          idle,
   output logic                          protocol_err
);
   logic [TAG_WIDTH-1:0]                  ptr_q, ptr_d, win_idx, idx;
   logic                                  win_found, fire, match;
   logic                                  vin_q, vin_d;
   logic [TAG_WIDTH-1:0]                  iss_tag_q, iss_tag_d;
   logic [2:0]                            op_q, op_d;
   logic [DATA_WIDTH-1:0]                 a_q, a_d, b_q, b_d;
   logic [FPU_LATENCY-1:0]                tv_q, tv_d;
   logic [FPU_LATENCY-1:0][TAG_WIDTH-1:0] tt_q, tt_d;
   logic [NUM_REQ-1:0]                    rv_q, rv_d;
   logic [DATA_WIDTH-1:0]                 rr_q, rr_d;
   logic                                  rx_q, rx_d;
   logic                                  perr_q, perr_d;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = TAG_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   // rst_n gating keeps ready at zero while reset is held, even with requests pending
   assign fire      = rst_n & arb_en & win_found;
   assign req_ready = fire ? (NUM_REQ'(1) << win_idx) : '0;
   assign match     = fpu_valid_out & tv_q[FPU_LATENCY-1];

   // the issue register is the head of the tag pipeline; tv_q tracks the FPU's own latency
   always_comb begin
      ptr_d     = fire ? win_idx : ptr_q;
      vin_d     = fire;
      iss_tag_d = win_idx;
      op_d      = fire ? req_op[3*win_idx +: 3] : op_q;
      a_d       = fire ? req_a[DATA_WIDTH*win_idx +: DATA_WIDTH] : a_q;
      b_d       = fire ? req_b[DATA_WIDTH*win_idx +: DATA_WIDTH] : b_q;
      tv_d      = tv_q;
      tt_d      = tt_q;
      tv_d[0]   = vin_q;
      tt_d[0]   = iss_tag_q;
      for (int s = 1; s < FPU_LATENCY; s++) begin
         tv_d[s] = tv_q[s-1];
         tt_d[s] = tt_q[s-1];
      end
      rv_d   = match ? (NUM_REQ'(1) << tt_q[FPU_LATENCY-1]) : '0;
      rr_d   = match ? fpu_result : rr_q;
      rx_d   = match ? fpu_exception : rx_q;
      perr_d = perr_q | (fpu_valid_out ^ tv_q[FPU_LATENCY-1]);
   end

   always_ff @(posedge clk_gated or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= TAG_WIDTH'(NUM_REQ-1);
         vin_q     <= 1'b0;
         iss_tag_q <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         tv_q      <= '0;
         tt_q      <= '0;
         rv_q      <= '0;
         rr_q      <= '0;
         rx_q      <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         vin_q     <= vin_d;
         iss_tag_q <= iss_tag_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         tv_q      <= tv_d;
         tt_q      <= tt_d;
         rv_q      <= rv_d;
         rr_q      <= rr_d;
         rx_q      <= rx_d;
         perr_q    <= perr_d;
      end
   end

   assign fpu_valid_in  = vin_q;
   assign fpu_operation = op_q;
   assign fpu_operand_a = a_q;
   assign fpu_operand_b = b_q;
   assign rsp_valid     = rv_q;
   assign rsp_result    = rr_q;
   assign rsp_exception = rx_q;
   assign protocol_err  = perr_q;
   assign idle          = !vin_q & ~|tv_q & ~|rv_q;
endmodule

// File: tb/tb_fpu_req_arbiter.sv
// tb_fpu_req_arbiter: scenario tasks plus a scoreboard that pairs each accepted
// request with its response; a two-stage stub stands in for the FPU.
module tb_fpu_req_arbiter;
   logic        clk_gated = 1'b0;
   logic        rst_n, arb_en, spur;
   logic [3:0]  req_valid, req_ready, rsp_valid;
   logic [11:0] req_op;
   logic [127:0] req_a, req_b;
   logic        fpu_valid_in, fpu_valid_out, fpu_exception, rsp_exception, idle, protocol_err;
   logic [2:0]  fpu_operation;
   logic [31:0] fpu_operand_a, fpu_operand_b, fpu_result, rsp_result;
   logic [2:0]  op_arr [4];
   logic [31:0] a_arr [4];
   logic [31:0] b_arr [4];
   logic        s1_v, s2_v, s1_x, s2_x;
   logic [31:0] s1_r, s2_r;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] res;
      logic        exc;
   } exp_t;
   exp_t q[$];
   exp_t e_mon;
   int   errors = 0;
   int   checks = 0;
   int   rsp_cnt = 0;

   always #5 clk_gated = ~clk_gated;

   fpu_req_arbiter dut (
      .clk_gated(clk_gated), .rst_n(rst_n), .arb_en(arb_en),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .fpu_valid_in(fpu_valid_in), .fpu_operation(fpu_operation),
      .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
      .fpu_valid_out(fpu_valid_out), .fpu_result(fpu_result), .fpu_exception(fpu_exception),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_exception(rsp_exception),
      .idle(idle), .protocol_err(protocol_err)
   );

   function automatic logic [31:0] fake_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      return (op == 3'd0 && a == 32'h3F800000 && b == 32'h3F800000) ? 32'h40000000
             : (a ^ {b[30:0], b[31]}) + {29'd0, op};
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         req_op[3*i +: 3]  = op_arr[i];
         req_a[32*i +: 32] = a_arr[i];
         req_b[32*i +: 32] = b_arr[i];
      end
   end

   // FPU stand-in: latency 2 from the edge that samples fpu_valid_in
   always @(posedge clk_gated or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0; s2_v <= 1'b0; s1_x <= 1'b0; s2_x <= 1'b0; s1_r <= '0; s2_r <= '0;
      end else begin
         s1_v <= fpu_valid_in;
         s1_r <= fake_res(fpu_operation, fpu_operand_a, fpu_operand_b);
         s1_x <= fpu_operation[2];
         s2_v <= s1_v; s2_r <= s1_r; s2_x <= s1_x;
      end
   end
   assign fpu_valid_out = s2_v | spur;
   assign fpu_result    = s2_r;
   assign fpu_exception = s2_x;

   always @(negedge clk_gated) begin
      if (rst_n) begin
         if (rsp_valid != 4'b0) begin
            rsp_cnt++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected rsp_valid=%b result=%h", rsp_valid, rsp_result);
            end else begin
               e_mon = q.pop_front();
               if (rsp_valid !== (4'b1 << e_mon.id) || rsp_result !== e_mon.res || rsp_exception !== e_mon.exc) begin
                  errors++;
                  $display("FAIL sb_rsp got=%b/%h/%b want=%b/%h/%b", rsp_valid, rsp_result, rsp_exception,
                           4'b1 << e_mon.id, e_mon.res, e_mon.exc);
               end
            end
         end
         for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready[i])
               q.push_back('{id: 2'(i), res: fake_res(op_arr[i], a_arr[i], b_arr[i]), exc: op_arr[i][2]});
      end
   end

   task automatic next_cycle();
      @(posedge clk_gated);
      #1;
   endtask

   task automatic apply_reset();
      next_cycle();
      rst_n = 1'b0; req_valid = '0; arb_en = 1'b1; spur = 1'b0;
      q.delete();
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || !idle) && n < 40) begin
         @(negedge clk_gated);
         n++;
      end
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      #3;
      checks++;
      if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
      checks++;
      if ({fpu_valid_in, fpu_operation, fpu_operand_a, fpu_operand_b} !== 68'd0) begin
         errors++; $display("FAIL reset_issue got=%b/%h/%h/%h want=0", fpu_valid_in, fpu_operation, fpu_operand_a, fpu_operand_b);
      end
      checks++;
      if ({rsp_valid, rsp_result, rsp_exception, protocol_err, idle} !== {4'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL reset_rsp got=%b/%h/%b/%b/%b want=0/0/0/0/1", rsp_valid, rsp_result, rsp_exception, protocol_err, idle);
      end
      req_valid = '0;
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      next_cycle();
      op_arr[0] = 3'd0; a_arr[0] = 32'h3F800000; b_arr[0] = 32'h3F800000;
      req_valid = 4'b0001;
      @(negedge clk_gated);
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b want=0001", req_ready); end
      next_cycle();
      req_valid = '0;
      @(negedge clk_gated);
      checks++;
      if ({fpu_valid_in, fpu_operation, fpu_operand_a, fpu_operand_b} !== {1'b1, 3'd0, 32'h3F800000, 32'h3F800000}) begin
         errors++; $display("FAIL single_issue got=%b/%h/%h/%h want=1/0/3f800000/3f800000", fpu_valid_in, fpu_operation, fpu_operand_a, fpu_operand_b);
      end
      repeat (2) @(negedge clk_gated);
      checks++;
      if (rsp_valid !== 4'b0) begin errors++; $display("FAIL single_early got=%b want=0000", rsp_valid); end
      @(negedge clk_gated);
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_result !== 32'h40000000) begin
         errors++; $display("FAIL single_rsp got=%b/%h want=0001/40000000", rsp_valid, rsp_result);
      end
      @(negedge clk_gated);
      checks++;
      if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got=%b want=1", idle); end
   endtask

   task automatic test_round_robin();
      int base;
      apply_reset();
      base = rsp_cnt;
      for (int i = 0; i < 4; i++) begin
         op_arr[i] = (i == 3) ? 3'b100 : 3'(i);
         a_arr[i]  = 32'h1000_0000 * (i + 1) + 32'h55;
         b_arr[i]  = 32'h0000_0F00 + i;
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_gated);
         checks++;
         if (req_ready !== (4'b1 << (k % 4))) begin errors++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_ready, 4'b1 << (k % 4)); end
         if (k >= 4) begin
            checks++;
            if (rsp_valid !== (4'b1 << ((k - 4) % 4))) begin errors++; $display("FAIL rr_rsp k=%0d got=%b want=%b", k, rsp_valid, 4'b1 << ((k - 4) % 4)); end
         end
         next_cycle();
      end
      req_valid = '0;
      drain();
      checks++;
      if (q.size() != 0 || rsp_cnt - base != 8) begin errors++; $display("FAIL rr_drain pending=%0d responses=%0d want=0/8", q.size(), rsp_cnt - base); end
   endtask

   task automatic test_rr_partial();
      logic [3:0] want [3] = '{4'b1000, 4'b0010, 4'b1000};
      apply_reset();
      op_arr[1] = 3'd2; a_arr[1] = 32'hAAAA_0001; b_arr[1] = 32'h1234_5678;
      op_arr[3] = 3'd3; a_arr[3] = 32'hBBBB_0003; b_arr[3] = 32'h8765_4321;
      req_valid = 4'b0010;
      @(negedge clk_gated);
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL part_setup got=%b want=0010", req_ready); end
      next_cycle();
      req_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_gated);
         checks++;
         if (req_ready !== want[k]) begin errors++; $display("FAIL part_grant k=%0d got=%b want=%b", k, req_ready, want[k]); end
         next_cycle();
      end
      req_valid = '0;
      drain();
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL part_drain pending=%0d want=0", q.size()); end
   endtask

   task automatic test_arb_en();
      apply_reset();
      op_arr[0] = 3'd1; a_arr[0] = 32'h0000_1111; b_arr[0] = 32'h0000_2222;
      op_arr[1] = 3'd2; a_arr[1] = 32'h0000_3333; b_arr[1] = 32'h0000_4444;
      op_arr[2] = 3'd0; a_arr[2] = 32'h0000_5555; b_arr[2] = 32'h0000_6666;
      req_valid = 4'b0011;
      @(negedge clk_gated);
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL en_grant0 got=%b want=0001", req_ready); end
      next_cycle();
      @(negedge clk_gated);
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL en_grant1 got=%b want=0010", req_ready); end
      next_cycle();
      req_valid = 4'b0100; arb_en = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_gated);
         checks++;
         if (req_ready !== 4'b0) begin errors++; $display("FAIL en_ready k=%0d got=%b want=0000", k, req_ready); end
         if (k == 2 && rsp_valid !== 4'b0001) begin errors++; $display("FAIL en_rsp0 got=%b want=0001", rsp_valid); end
         if (k == 3 && rsp_valid !== 4'b0010) begin errors++; $display("FAIL en_rsp1 got=%b want=0010", rsp_valid); end
         if (k == 4 && idle !== 1'b1) begin errors++; $display("FAIL en_idle got=%b want=1", idle); end
         next_cycle();
      end
      req_valid = '0; arb_en = 1'b1;
   endtask

   task automatic test_protocol_err();
      apply_reset();
      spur = 1'b1;
      @(negedge clk_gated);
      checks++;
      if (protocol_err !== 1'b0) begin errors++; $display("FAIL perr_early got=%b want=0", protocol_err); end
      next_cycle();
      spur = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_gated);
         checks++;
         if (protocol_err !== 1'b1 || rsp_valid !== 4'b0) begin
            errors++; $display("FAIL perr_sticky k=%0d got=%b/%b want=1/0000", k, protocol_err, rsp_valid);
         end
      end
   endtask

   task automatic test_reset_inflight();
      apply_reset();
      op_arr[0] = 3'd0; a_arr[0] = 32'hCAFE_0000; b_arr[0] = 32'h0000_BEEF;
      op_arr[1] = 3'd1; a_arr[1] = 32'hDEAD_0000; b_arr[1] = 32'h0000_F00D;
      req_valid = 4'b0011;
      next_cycle();
      next_cycle();
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      checks++;
      if ({fpu_valid_in, fpu_operation, fpu_operand_a, fpu_operand_b} !== 68'd0 || req_ready !== 4'b0) begin
         errors++; $display("FAIL rstf_issue got=%b/%h/%h/%h/%b want=0", fpu_valid_in, fpu_operation, fpu_operand_a, fpu_operand_b, req_ready);
      end
      checks++;
      if ({rsp_valid, rsp_result, rsp_exception, protocol_err, idle} !== {4'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL rstf_rsp got=%b/%h/%b/%b/%b want=0/0/0/0/1", rsp_valid, rsp_result, rsp_exception, protocol_err, idle);
      end
      next_cycle();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_gated);
         checks++;
         if (rsp_valid !== 4'b0 || protocol_err !== 1'b0) begin
            errors++; $display("FAIL rstf_quiet k=%0d got=%b/%b want=0000/0", k, rsp_valid, protocol_err);
         end
      end
      checks++;
      if (idle !== 1'b1) begin errors++; $display("FAIL rstf_idle got=%b want=1", idle); end
   endtask

   initial begin
      rst_n = 1'b0; arb_en = 1'b1; spur = 1'b0; req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         op_arr[i] = '0; a_arr[i] = '0; b_arr[i] = '0;
      end
      test_reset();
      test_single();
      test_round_robin();
      test_rr_partial();
      test_arb_en();
      test_protocol_err();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
